// File: rtl/riscv_exu_wb_arb.sv
// Writeback arbiter for the execute stage: round-robin grant of the single register
// write port among N_REQ execute units, with a one-cycle output stage and RVFI retire stamping.
package riscv_pkg;
   typedef struct packed {
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
   } rvfi_t;
endpackage

module riscv_exu_wb_arb #(
   parameter int N_REQ = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_vld,
   input  logic [N_REQ-1:0][4:0]        req_rd,
   input  logic [N_REQ-1:0]             req_rd_used,
   input  logic [N_REQ-1:0][31:0]       req_data,
   input  riscv_pkg::rvfi_t [N_REQ-1:0] req_rvfi,
   output logic [N_REQ-1:0]             req_rdy,
   output logic                         register_write_en,
   output logic [4:0]                   register_write,
   output logic [31:0]                  register_write_data,
   output logic                         register_unlock_en,
   output logic [4:0]                   register_unlock,
   output logic                         rvfi_valid,
   output riscv_pkg::rvfi_t             rvfi,
   output logic [63:0]                  retire_count
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  win;
   logic              found;

   logic              out_vld;
   logic [4:0]        out_rd;
   logic              out_rd_used;
   logic [31:0]       out_data;
   riscv_pkg::rvfi_t  out_rvfi;
   logic              out_writes_rd;

   // Grant depends only on req_vld and rr_ptr, so no path exists from our outputs back to req_rdy.
   always_comb begin
      int idx;
      found   = 1'b0;
      win     = '0;
      req_rdy = '0;
      idx     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_vld[idx]) begin
            found = 1'b1;
            win   = idx[PTR_W-1:0];
         end
      end
      if (found) req_rdy[win] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (found) begin
         rr_ptr <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
      end
   end

   // Payload is held after retirement; only the valid bit decides whether it is acted on.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_vld     <= 1'b0;
         out_rd      <= '0;
         out_rd_used <= 1'b0;
         out_data    <= '0;
         out_rvfi    <= '0;
      end else begin
         out_vld <= found;
         if (found) begin
            out_rd      <= req_rd[win];
            out_rd_used <= req_rd_used[win];
            out_data    <= req_data[win];
            out_rvfi    <= req_rvfi[win];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         retire_count <= '0;
      end else if (out_vld) begin
         retire_count <= retire_count + 64'd1;
      end
   end

   // x0 destinations retire normally but never write or unlock.
   assign out_writes_rd       = out_vld & out_rd_used & (out_rd != 5'd0);
   assign register_write_en   = out_writes_rd;
   assign register_write      = out_rd;
   assign register_write_data = out_data;
   assign register_unlock_en  = out_writes_rd;
   assign register_unlock     = out_rd;
   assign rvfi_valid          = out_vld;

   always_comb begin
      rvfi       = out_rvfi;
      rvfi.order = retire_count;
   end

endmodule

// File: tb/tb_riscv_exu_wb_arb.sv
// Directed bench for riscv_exu_wb_arb: a 3-unit instance for arbitration, x0, stall and
// async-reset behaviour, plus a 1-unit instance for back-to-back retirement.
module tb_riscv_exu_wb_arb;

   logic                     clock;
   logic                     reset;

   logic [2:0]               req_vld;
   logic [2:0][4:0]          req_rd;
   logic [2:0]               req_rd_used;
   logic [2:0][31:0]         req_data;
   riscv_pkg::rvfi_t [2:0]   req_rvfi;
   logic [2:0]               req_rdy;
   logic                     register_write_en;
   logic [4:0]               register_write;
   logic [31:0]              register_write_data;
   logic                     register_unlock_en;
   logic [4:0]               register_unlock;
   logic                     rvfi_valid;
   riscv_pkg::rvfi_t         rvfi;
   logic [63:0]              retire_count;

   logic [0:0]               req_vld1;
   logic [0:0][4:0]          req_rd1;
   logic [0:0]               req_rd_used1;
   logic [0:0][31:0]         req_data1;
   riscv_pkg::rvfi_t [0:0]   req_rvfi1;
   logic [0:0]               req_rdy1;
   logic                     register_write_en1;
   logic [4:0]               register_write1;
   logic [31:0]              register_write_data1;
   logic                     register_unlock_en1;
   logic [4:0]               register_unlock1;
   logic                     rvfi_valid1;
   riscv_pkg::rvfi_t         rvfi1;
   logic [63:0]              retire_count1;

   int vectors;
   int miscompares;
   logic [31:0] cur_data [3];
   logic [31:0] exp_data;
   int g;

   riscv_exu_wb_arb #(.N_REQ(3)) dut (
      .clock(clock), .reset(reset),
      .req_vld(req_vld), .req_rd(req_rd), .req_rd_used(req_rd_used),
      .req_data(req_data), .req_rvfi(req_rvfi), .req_rdy(req_rdy),
      .register_write_en(register_write_en), .register_write(register_write),
      .register_write_data(register_write_data), .register_unlock_en(register_unlock_en),
      .register_unlock(register_unlock), .rvfi_valid(rvfi_valid), .rvfi(rvfi),
      .retire_count(retire_count)
   );

   riscv_exu_wb_arb #(.N_REQ(1)) dut1 (
      .clock(clock), .reset(reset),
      .req_vld(req_vld1), .req_rd(req_rd1), .req_rd_used(req_rd_used1),
      .req_data(req_data1), .req_rvfi(req_rvfi1), .req_rdy(req_rdy1),
      .register_write_en(register_write_en1), .register_write(register_write1),
      .register_write_data(register_write_data1), .register_unlock_en(register_unlock_en1),
      .register_unlock(register_unlock1), .rvfi_valid(rvfi_valid1), .rvfi(rvfi1),
      .retire_count(retire_count1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic riscv_pkg::rvfi_t mkRvfi(input logic [31:0] insn, input logic [4:0] rd,
                                                 input logic [31:0] wdata);
      riscv_pkg::rvfi_t r;
      r          = '0;
      r.order    = 64'hFFFF_0000_DEAD_0000;
      r.insn     = insn;
      r.rd_addr  = rd;
      r.rd_wdata = wdata;
      return r;
   endfunction

   task automatic applyStimulus(input int unit, input logic vld, input logic [4:0] rd,
                                input logic used, input logic [31:0] data, input logic [31:0] insn);
      req_vld[unit]     = vld;
      req_rd[unit]      = rd;
      req_rd_used[unit] = used;
      req_data[unit]    = data;
      req_rvfi[unit]    = mkRvfi(insn, rd, data);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b0;
      req_vld      = '0;
      req_rd       = '0;
      req_rd_used  = '0;
      req_data     = '0;
      req_rvfi     = '0;
      req_vld1     = '0;
      req_rd1      = '0;
      req_rd_used1 = '0;
      req_data1    = '0;
      req_rvfi1    = '0;

      // Reset values
      #7;
      checkOutput("rst_rdy", 64'(req_rdy), 64'd0);
      checkOutput("rst_wen", 64'(register_write_en), 64'd0);
      checkOutput("rst_wr", 64'(register_write), 64'd0);
      checkOutput("rst_wdata", 64'(register_write_data), 64'd0);
      checkOutput("rst_uen", 64'(register_unlock_en), 64'd0);
      checkOutput("rst_unlock", 64'(register_unlock), 64'd0);
      checkOutput("rst_rvfi_valid", 64'(rvfi_valid), 64'd0);
      checkOutput("rst_retire", retire_count, 64'd0);
      vectors++;
      assert (rvfi === '0)
      else begin
         miscompares++;
         $error("[TB] FAIL rst_rvfi: observed=0x%0h expected=0", rvfi);
      end

      // Single ALU result
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(0, 1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 32'h00A00013);
      #1 checkOutput("t1_rdy", 64'(req_rdy), 64'b001);
      @(negedge clock);
      req_vld = '0;
      checkOutput("t1_wen", 64'(register_write_en), 64'd1);
      checkOutput("t1_wr", 64'(register_write), 64'd5);
      checkOutput("t1_wdata", 64'(register_write_data), 64'hDEADBEEF);
      checkOutput("t1_uen", 64'(register_unlock_en), 64'd1);
      checkOutput("t1_unlock", 64'(register_unlock), 64'd5);
      checkOutput("t1_rvfi_valid", 64'(rvfi_valid), 64'd1);
      checkOutput("t1_order", rvfi.order, 64'd0);
      checkOutput("t1_insn", 64'(rvfi.insn), 64'h00A00013);
      #1 checkOutput("t1_rdy_idle", 64'(req_rdy), 64'd0);
      @(negedge clock);
      checkOutput("t1_retire", retire_count, 64'd1);
      checkOutput("t1_rvfi_drop", 64'(rvfi_valid), 64'd0);
      checkOutput("t1_wen_drop", 64'(register_write_en), 64'd0);

      // Stall stability with rr_ptr=1: unit 1 first, unit 0 holds its data
      applyStimulus(0, 1'b1, 5'd7, 1'b1, 32'h12345678, 32'h00000011);
      applyStimulus(1, 1'b1, 5'd8, 1'b1, 32'hAAAA0001, 32'h00000022);
      #1 checkOutput("stall_rdy1", 64'(req_rdy), 64'b010);
      @(negedge clock);
      req_vld[1] = 1'b0;
      checkOutput("stall_wr1", 64'(register_write), 64'd8);
      checkOutput("stall_wdata1", 64'(register_write_data), 64'hAAAA0001);
      checkOutput("stall_order1", rvfi.order, 64'd1);
      #1 checkOutput("stall_rdy0", 64'(req_rdy), 64'b001);
      @(negedge clock);
      req_vld[0] = 1'b0;
      checkOutput("stall_wr0", 64'(register_write), 64'd7);
      checkOutput("stall_wdata0", 64'(register_write_data), 64'h12345678);
      checkOutput("stall_unlock0", 64'(register_unlock), 64'd7);
      checkOutput("stall_order0", rvfi.order, 64'd2);

      // x0 destination from the LSU, then a store without rd
      applyStimulus(1, 1'b1, 5'd0, 1'b1, 32'h5555AAAA, 32'h00000033);
      #1 checkOutput("x0_rdy", 64'(req_rdy), 64'b010);
      @(negedge clock);
      req_vld[1] = 1'b0;
      checkOutput("x0_rvfi_valid", 64'(rvfi_valid), 64'd1);
      checkOutput("x0_wen", 64'(register_write_en), 64'd0);
      checkOutput("x0_uen", 64'(register_unlock_en), 64'd0);
      checkOutput("x0_rd_addr", 64'(rvfi.rd_addr), 64'd0);
      checkOutput("x0_rd_wdata", 64'(rvfi.rd_wdata), 64'h5555AAAA);
      checkOutput("x0_order", rvfi.order, 64'd3);
      applyStimulus(2, 1'b1, 5'd3, 1'b0, 32'h0BADF00D, 32'h00000044);
      #1 checkOutput("st_rdy", 64'(req_rdy), 64'b100);
      @(negedge clock);
      req_vld[2] = 1'b0;
      checkOutput("st_rvfi_valid", 64'(rvfi_valid), 64'd1);
      checkOutput("st_wen", 64'(register_write_en), 64'd0);
      checkOutput("st_uen", 64'(register_unlock_en), 64'd0);
      checkOutput("st_wr", 64'(register_write), 64'd3);
      checkOutput("st_order", rvfi.order, 64'd4);
      @(negedge clock);
      checkOutput("st_retire", retire_count, 64'd5);

      // Full contention starting from rr_ptr=0: grants 0,1,2,0,1,2
      for (int i = 0; i < 3; i++) begin
         cur_data[i] = 32'hC000_0000 + (32'(i) << 16);
         applyStimulus(i, 1'b1, 5'(10 + i), 1'b1, cur_data[i], 32'h100 + 32'(i));
      end
      for (int k = 0; k < 6; k++) begin
         g = k % 3;
         #1 checkOutput("cont_rdy", 64'(req_rdy), 64'(3'b001 << g));
         exp_data = cur_data[g];
         @(negedge clock);
         checkOutput("cont_rvfi_valid", 64'(rvfi_valid), 64'd1);
         checkOutput("cont_wdata", 64'(register_write_data), 64'(exp_data));
         checkOutput("cont_wr", 64'(register_write), 64'(10 + g));
         checkOutput("cont_order", rvfi.order, 64'(5 + k));
         cur_data[g] = exp_data + 32'd1;
         applyStimulus(g, 1'b1, 5'(10 + g), 1'b1, cur_data[g], 32'h200 + 32'(k));
         if (k == 5) req_vld = '0;
      end
      @(negedge clock);
      checkOutput("cont_idle", 64'(rvfi_valid), 64'd0);
      checkOutput("cont_retire", retire_count, 64'd11);

      // Async reset while a result sits in the output stage
      applyStimulus(0, 1'b1, 5'd6, 1'b1, 32'hFEEDFACE, 32'h00000055);
      #1 checkOutput("ar_rdy", 64'(req_rdy), 64'b001);
      @(negedge clock);
      req_vld = '0;
      checkOutput("ar_pre_valid", 64'(rvfi_valid), 64'd1);
      checkOutput("ar_pre_wen", 64'(register_write_en), 64'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("ar_valid", 64'(rvfi_valid), 64'd0);
      checkOutput("ar_wen", 64'(register_write_en), 64'd0);
      checkOutput("ar_uen", 64'(register_unlock_en), 64'd0);
      checkOutput("ar_wr", 64'(register_write), 64'd0);
      checkOutput("ar_retire", retire_count, 64'd0);
      applyStimulus(0, 1'b1, 5'd12, 1'b1, 32'h0F0F0F0F, 32'h00000066);
      applyStimulus(2, 1'b1, 5'd13, 1'b1, 32'hF0F0F0F0, 32'h00000077);
      @(negedge clock);
      reset = 1'b1;
      #1 checkOutput("ar_first_rdy", 64'(req_rdy), 64'b001);
      @(negedge clock);
      req_vld[0] = 1'b0;
      checkOutput("ar_first_wr", 64'(register_write), 64'd12);
      checkOutput("ar_first_order", rvfi.order, 64'd0);
      #1 checkOutput("ar_second_rdy", 64'(req_rdy), 64'b100);
      @(negedge clock);
      req_vld = '0;
      checkOutput("ar_second_wr", 64'(register_write), 64'd13);
      checkOutput("ar_second_order", rvfi.order, 64'd1);
      @(negedge clock);
      checkOutput("ar_retire_after", retire_count, 64'd2);

      // Single-unit build retires every cycle
      exp_data        = 32'h7000_0000;
      req_vld1[0]     = 1'b1;
      req_rd1[0]      = 5'd9;
      req_rd_used1[0] = 1'b1;
      req_data1[0]    = exp_data;
      req_rvfi1[0]    = mkRvfi(32'h300, 5'd9, exp_data);
      for (int k = 0; k < 4; k++) begin
         #1 checkOutput("n1_rdy", 64'(req_rdy1), 64'd1);
         @(negedge clock);
         checkOutput("n1_rvfi_valid", 64'(rvfi_valid1), 64'd1);
         checkOutput("n1_order", rvfi1.order, 64'(k));
         checkOutput("n1_wdata", 64'(register_write_data1), 64'(32'h7000_0000 + 32'(k)));
         exp_data     = 32'h7000_0000 + 32'(k + 1);
         req_data1[0] = exp_data;
         req_rvfi1[0] = mkRvfi(32'h300 + 32'(k + 1), 5'd9, exp_data);
         if (k == 3) req_vld1[0] = 1'b0;
      end
      @(negedge clock);
      checkOutput("n1_retire", retire_count1, 64'd4);
      checkOutput("n1_idle", 64'(rvfi_valid1), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_exu_wb_arb.md
# riscv_exu_wb_arb

Writeback arbiter for the execute stage. It shares the single architectural register write port (port 0) between up to N_REQ execute units (ALU, load/store, multiply/divide). It uses round-robin order and a valid/ready handshake per unit. Each granted result is registered for one cycle, then driven onto the register write port. In the same cycle it releases the destination-register lock, emits the RVFI retire record, and stamps that record with a monotonically increasing retire order.

## Interface
- N_REQ, default 3: number of requesting units. Index 0 = ALU, 1 = LSU, 2 = MDU. Legal range 1..8.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. State is cleared while reset is 0; normal operation when reset is 1.
- req_vld  in  N_REQ  unit i has a completed result.
- req_rd  in  N_REQ x 5  destination register of unit i.
- req_rd_used  in  N_REQ  the result writes rd. When 0, the op retires without a register write (stores, branches).
- req_data  in  N_REQ x 32  result data of unit i.
- req_rvfi  in  N_REQ x riscv_pkg::rvfi_t  retire record of unit i.
- req_rdy  out  N_REQ  grant. The handshake completes when req_vld[i] & req_rdy[i].
- register_write_en  out  1  write strobe for register port 0.
- register_write  out  5  write index.
- register_write_data  out  32  write data.
- register_unlock_en  out  1  clear the lock bit of register_unlock.
- register_unlock  out  5  register whose lock is released.
- rvfi_valid  out  1  one instruction retires this cycle.
- rvfi  out  riscv_pkg::rvfi_t  retire record with order replaced.
- retire_count  out  64  number of retired instructions; equals the next order value.

## Operation
- Requester contract:
  - req_rd, req_rd_used, req_data and req_rvfi stay stable while req_vld=1 and req_rdy=0.
  - req_vld must not drop before the handshake.
- Grant logic is combinational from req_vld and rr_ptr:
  - The search starts at index rr_ptr and wraps modulo N_REQ.
  - The first set req_vld wins, and only its req_rdy is 1.
  - At most one req_rdy is high per cycle. With no valid request, all req_rdy are 0.
  - req_rdy never depends on any output of this block, so there is no combinational loop.
- On a handshake with winner w:
  - Capture into the output stage: rd, rd_used, data, rvfi.
  - Set the output-stage valid.
  - Set rr_ptr to (w+1) mod N_REQ.
- With no handshake:
  - Output-stage valid is cleared.
  - rr_ptr holds.
- Output stage drives, for the cycle after the handshake:
  - rvfi_valid = 1.
  - rvfi = captured record, with field order set to retire_count.
  - register_write_en = rd_used & (rd != 0). Writes to x0 are suppressed.
  - register_write = rd and register_write_data = data, regardless of the enable.
  - register_unlock_en = rd_used & (rd != 0), with register_unlock = rd.
  - retire_count increments by 1 on the same edge that retires the output stage (64-bit wrap, never reached in practice).
- x0 destination:
  - The handshake still completes and rvfi_valid still pulses.
  - There is no write and no unlock.
  - rvfi.rd_addr and rvfi.rd_wdata pass through unchanged from the requester.
- N_REQ=1: rr_ptr stays 0 and the grant is req_vld[0].

## Timing
- Reset values:
  - req_rdy = 0 (no requests are valid).
  - register_write_en = 0; register_write = 0; register_write_data = 0.
  - register_unlock_en = 0; register_unlock = 0.
  - rvfi_valid = 0; rvfi = '0.
  - retire_count = 0; rr_ptr = 0.
- Latency: handshake in cycle T gives write, unlock and rvfi in cycle T+1.
- Throughput: one result per cycle sustained. The output stage never back-pressures.
- Fairness:
  - A requester holding req_vld is granted within N_REQ cycles.
  - Under full load the grant order is 0,1,2,0,1,2…
- Simultaneous events:
  - Two units completing to the same rd in the same cycle retire in round-robin order. Each write and unlock appears in its own cycle.
  - A register written in T+1 is visible to the register file in T+2. The lock clears in T+2.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronous).
  - An in-flight captured result is discarded and retire_count returns to 0.
- Reset deasserted: the first grant is possible in the same cycle.

## Test plan
- Single ALU result: req_vld[0]=1, rd=5, rd_used=1, data=0xDEADBEEF in cycle 1.
  - Cycle 1: req_rdy[0]=1.
  - Cycle 2: register_write_en=1, register_write=5, data 0xDEADBEEF, unlock 5, rvfi_valid=1, rvfi.order=0.
  - Cycle 3: retire_count=1.
- Full contention: all three req_vld held high for 6 cycles, with new data each handshake.
  - Grants are 0,1,2,0,1,2.
  - rvfi.order values are 0..5 in consecutive cycles.
  - rvfi_valid stays high for 6 cycles.
- x0 and no-rd:
  - LSU with rd=0, rd_used=1: rvfi_valid=1, register_write_en=0, register_unlock_en=0.
  - A store with rd_used=0: same response.
  - retire_count advances by 2.
- Stall stability: req_vld[0] and req_vld[1] both high, with rr_ptr=1.
  - Unit 1 is granted first. Unit 0 holds stable data 0x12345678 and is granted the next cycle.
  - The written data equals 0x12345678.
- Async reset: assert reset=0 mid-cycle one cycle after a handshake, before the output edge.
  - rvfi_valid and register_write_en drop to 0 immediately, with no clock edge.
  - After release: retire_count=0 and the first grant goes to the lowest valid index.
- N_REQ=1 build: continuous req_vld[0] retires one result every cycle with order 0,1,2,…
